// File: rtl/tcdm2axi_if.sv
// TCDM slave port and AXI4 master port of the tcdm2axi bridge.
// modport master: the bridge itself; modport slave: the TCDM initiator and AXI memory around it.
interface tcdm2axi_if #(
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic                        tcdm_req_i;
    logic [31:0]                 tcdm_add_i;
    logic                        tcdm_wen_i;
    logic [3:0]                  tcdm_be_i;
    logic [31:0]                 tcdm_data_i;
    logic                        tcdm_gnt_o;
    logic                        tcdm_r_valid_o;
    logic [31:0]                 tcdm_r_data_o;

    logic                        axi_aw_valid_o;
    logic                        axi_aw_ready_i;
    logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o;
    logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o;
    logic [7:0]                  axi_aw_len_o;
    logic [2:0]                  axi_aw_size_o;
    logic [1:0]                  axi_aw_burst_o;

    logic                        axi_w_valid_o;
    logic                        axi_w_ready_i;
    logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o;
    logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o;
    logic                        axi_w_last_o;

    logic                        axi_b_valid_i;
    logic [AXI_ID_WIDTH-1:0]     axi_b_id_i;
    logic [1:0]                  axi_b_resp_i;
    logic                        axi_b_ready_o;

    logic                        axi_ar_valid_o;
    logic                        axi_ar_ready_i;
    logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o;
    logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o;
    logic [7:0]                  axi_ar_len_o;
    logic [2:0]                  axi_ar_size_o;
    logic [1:0]                  axi_ar_burst_o;

    logic                        axi_r_valid_i;
    logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i;
    logic [1:0]                  axi_r_resp_i;
    logic                        axi_r_last_i;
    logic [AXI_ID_WIDTH-1:0]     axi_r_id_i;
    logic                        axi_r_ready_o;

    modport master (
        input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
        output tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_data_o,
        output axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
        input  axi_aw_ready_i,
        output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        input  axi_w_ready_i,
        input  axi_b_valid_i, axi_b_id_i, axi_b_resp_i,
        output axi_b_ready_o,
        output axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
        input  axi_ar_ready_i,
        input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_id_i,
        output axi_r_ready_o
    );

    modport slave (
        output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
        input  tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_data_o,
        input  axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
        output axi_aw_ready_i,
        input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        output axi_w_ready_i,
        output axi_b_valid_i, axi_b_id_i, axi_b_resp_i,
        input  axi_b_ready_o,
        input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
        output axi_ar_ready_i,
        output axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_id_i,
        input  axi_r_ready_o
    );
endinterface

// File: rtl/tcdm2axi.sv
// Single-port TCDM slave that issues single-beat 32-bit AXI4 transactions, one outstanding.
// Optional macro TCDM2AXI_ERR_CNT_EN adds a sticky error flag and a saturating error counter.
//
//   state   | meaning
//   IDLE    | grant follows request; request fields are latched on grant
//   WR_REQ  | AW and W valid, each dropped after its own handshake
//   WR_RESP | waiting for B
//   RD_REQ  | AR valid until accepted
//   RD_RESP | waiting for R, selected 32-bit half captured
//   RSP     | one-cycle TCDM response pulse
module tcdm2axi #(
    parameter int                      AXI_ID_WIDTH   = 8,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0,
    parameter int                      AXI_ADDR_WIDTH = 32,
    parameter int                      AXI_DATA_WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    tcdm2axi_if.master bus,
    output logic       busy_o
`ifdef TCDM2AXI_ERR_CNT_EN
    ,
    output logic       err_o,
    output logic [7:0] err_cnt_o
`endif
);
    if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("tcdm2axi: AXI_DATA_WIDTH must be 64");
    end

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    state_t      state_q;
    logic [29:0] add_q;
    logic [3:0]  be_q;
    logic [31:0] data_q;
    logic        aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
    logic        r_valid_q;
    logic [31:0] r_data_q;
    logic        busy_q;
`ifdef TCDM2AXI_ERR_CNT_EN
    logic        err_q;
    logic [7:0]  err_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            add_q      <= '0;
            be_q       <= '0;
            data_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            busy_q     <= 1'b0;
`ifdef TCDM2AXI_ERR_CNT_EN
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tcdm_req_i) begin
                        add_q  <= bus.tcdm_add_i[31:2];
                        be_q   <= bus.tcdm_be_i;
                        data_q <= bus.tcdm_data_i;
                        busy_q <= 1'b1;
                        if (bus.tcdm_wen_i) begin
                            state_q    <= RD_REQ;
                            ar_valid_q <= 1'b1;
                        end else begin
                            state_q    <= WR_REQ;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (bus.axi_aw_ready_i) aw_valid_q <= 1'b0;
                    if (bus.axi_w_ready_i)  w_valid_q  <= 1'b0;
                    // a dropped valid means that channel already completed
                    if ((!aw_valid_q || bus.axi_aw_ready_i) && (!w_valid_q || bus.axi_w_ready_i)) begin
                        state_q   <= WR_RESP;
                        b_ready_q <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bus.axi_b_valid_i) begin
                        state_q   <= RSP;
                        b_ready_q <= 1'b0;
                        r_valid_q <= 1'b1;
                        r_data_q  <= '0;
                    end
                end
                RD_REQ: begin
                    if (bus.axi_ar_ready_i) begin
                        state_q    <= RD_RESP;
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (bus.axi_r_valid_i) begin
                        state_q   <= RSP;
                        r_ready_q <= 1'b0;
                        r_valid_q <= 1'b1;
                        r_data_q  <= add_q[0] ? bus.axi_r_data_i[63:32] : bus.axi_r_data_i[31:0];
                    end
                end
                RSP: begin
                    state_q   <= IDLE;
                    r_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
`ifdef TCDM2AXI_ERR_CNT_EN
            if ((state_q == WR_RESP && bus.axi_b_valid_i && bus.axi_b_resp_i != 2'b00) ||
                (state_q == RD_RESP && bus.axi_r_valid_i && bus.axi_r_resp_i != 2'b00)) begin
                err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
`endif
        end
    end

    assign bus.tcdm_gnt_o     = (state_q == IDLE) && bus.tcdm_req_i;
    assign bus.tcdm_r_valid_o = r_valid_q;
    assign bus.tcdm_r_data_o  = r_data_q;

    assign bus.axi_aw_valid_o = aw_valid_q;
    assign bus.axi_aw_addr_o  = AXI_ADDR_WIDTH'({add_q, 2'b00});
    assign bus.axi_aw_id_o    = AXI_ID;
    assign bus.axi_aw_len_o   = 8'd0;
    assign bus.axi_aw_size_o  = 3'b010;
    assign bus.axi_aw_burst_o = 2'b01;

    assign bus.axi_w_valid_o  = w_valid_q;
    assign bus.axi_w_data_o   = {data_q, data_q};
    assign bus.axi_w_strb_o   = add_q[0] ? {be_q, 4'h0} : {4'h0, be_q};
    assign bus.axi_w_last_o   = 1'b1;

    assign bus.axi_b_ready_o  = b_ready_q;

    assign bus.axi_ar_valid_o = ar_valid_q;
    assign bus.axi_ar_addr_o  = AXI_ADDR_WIDTH'({add_q, 2'b00});
    assign bus.axi_ar_id_o    = AXI_ID;
    assign bus.axi_ar_len_o   = 8'd0;
    assign bus.axi_ar_size_o  = 3'b010;
    assign bus.axi_ar_burst_o = 2'b01;

    assign bus.axi_r_ready_o  = r_ready_q;

    assign busy_o = busy_q;
`ifdef TCDM2AXI_ERR_CNT_EN
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`endif

    // response IDs, r_last and byte offset never steer the flow
    logic unused_inputs;
    assign unused_inputs = ^{bus.axi_b_id_i, bus.axi_r_id_i, bus.axi_r_last_i,
                             bus.axi_b_resp_i, bus.axi_r_resp_i, bus.tcdm_add_i[1:0]};
endmodule

// File: tb/tb_tcdm2axi.sv
// Bench for tcdm2axi: directed and random TCDM requests against a procedural AXI memory model.
module tb_tcdm2axi;
    logic clk;
    logic rst;
    logic busy;
    int   tests = 0;
    int   fails = 0;
    int   exp_err_cnt = 0;
    bit   exp_err = 0;
`ifdef TCDM2AXI_ERR_CNT_EN
    logic       err;
    logic [7:0] err_cnt;
`endif

    tcdm2axi_if #(.AXI_ID_WIDTH(8), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) bus ();

    tcdm2axi #(.AXI_ID_WIDTH(8), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy)
`ifdef TCDM2AXI_ERR_CNT_EN
        ,
        .err_o     (err),
        .err_cnt_o (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        bus.axi_aw_ready_i = 1'b0;
        bus.axi_w_ready_i  = 1'b0;
        bus.axi_b_valid_i  = 1'b0;
        bus.axi_b_id_i     = '0;
        bus.axi_b_resp_i   = 2'b00;
        bus.axi_ar_ready_i = 1'b0;
        bus.axi_r_valid_i  = 1'b0;
        bus.axi_r_data_i   = '0;
        bus.axi_r_resp_i   = 2'b00;
        bus.axi_r_last_i   = 1'b0;
        bus.axi_r_id_i     = '0;
    endtask

    task automatic check_err();
`ifdef TCDM2AXI_ERR_CNT_EN
        check("err_flag", err, exp_err);
        check("err_cnt", err_cnt, exp_err_cnt);
`endif
    endtask

    // One TCDM transaction, entered and left shortly after a rising edge with the DUT in IDLE.
    task automatic txn(input logic [31:0] a, input logic rd, input logic [3:0] be, input logic [31:0] d,
                       input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d,
                       input logic [63:0] rdat, input logic [1:0] resp, input logic hold, input logic chk_lat);
        logic [31:0] aw_addr = '0, ar_addr = '0;
        logic [7:0]  aw_len = 8'hFF, ar_len = 8'hFF, aw_id = 8'hFF, ar_id = 8'hFF;
        logic [2:0]  aw_size = '0, ar_size = '0;
        logic [1:0]  aw_burst = '0, ar_burst = '0;
        logic [63:0] w_data = '0;
        logic [7:0]  w_strb = '0;
        logic        w_last = 1'b0;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0;
        bit both_wr, ar_prev;
        int rv_cnt = 0, rv_cyc = -1, viol = 0, cyc;
        logic [31:0] rv_data = '0;
        logic [31:0] exp_addr;

        bus.tcdm_req_i  = 1'b1;
        bus.tcdm_add_i  = a;
        bus.tcdm_wen_i  = rd;
        bus.tcdm_be_i   = be;
        bus.tcdm_data_i = d;
        #1;
        check("gnt_in_idle", bus.tcdm_gnt_o, 1'b1);
        @(posedge clk); #1;
        if (!hold) bus.tcdm_req_i = 1'b0;
        check("busy_after_gnt", busy, 1'b1);
        cyc = 1;
        while (cyc < 80) begin
            if (bus.tcdm_r_valid_o) begin
                if (rv_cnt == 0) begin
                    rv_cyc  = cyc;
                    rv_data = bus.tcdm_r_data_o;
                end
                rv_cnt++;
            end
            if (rv_cnt > 0 && cyc > rv_cyc) break;
            if (bus.tcdm_gnt_o) viol++;
            if (rd && (bus.axi_aw_valid_o || bus.axi_w_valid_o)) viol++;
            if (!rd && bus.axi_ar_valid_o) viol++;
            both_wr = aw_done && w_done;
            ar_prev = ar_done;

            bus.axi_aw_ready_i = 1'b0;
            if (bus.axi_aw_valid_o) begin
                if (aw_done) viol++;
                else if (aw_cnt >= aw_d) begin
                    bus.axi_aw_ready_i = 1'b1;
                    aw_done = 1;
                    aw_addr = bus.axi_aw_addr_o; aw_len = bus.axi_aw_len_o; aw_id = bus.axi_aw_id_o;
                    aw_size = bus.axi_aw_size_o; aw_burst = bus.axi_aw_burst_o;
                end else aw_cnt++;
            end
            bus.axi_w_ready_i = 1'b0;
            if (bus.axi_w_valid_o) begin
                if (w_done) viol++;
                else if (w_cnt >= w_d) begin
                    bus.axi_w_ready_i = 1'b1;
                    w_done = 1;
                    w_data = bus.axi_w_data_o; w_strb = bus.axi_w_strb_o; w_last = bus.axi_w_last_o;
                end else w_cnt++;
            end
            bus.axi_b_valid_i = 1'b0;
            if (both_wr && !b_done) begin
                if (b_cnt >= b_d) begin
                    bus.axi_b_valid_i = 1'b1;
                    bus.axi_b_resp_i  = resp;
                    if (bus.axi_b_ready_o) b_done = 1;
                end else b_cnt++;
            end
            bus.axi_ar_ready_i = 1'b0;
            if (bus.axi_ar_valid_o) begin
                if (ar_done) viol++;
                else if (ar_cnt >= ar_d) begin
                    bus.axi_ar_ready_i = 1'b1;
                    ar_done = 1;
                    ar_addr = bus.axi_ar_addr_o; ar_len = bus.axi_ar_len_o; ar_id = bus.axi_ar_id_o;
                    ar_size = bus.axi_ar_size_o; ar_burst = bus.axi_ar_burst_o;
                end else ar_cnt++;
            end
            bus.axi_r_valid_i = 1'b0;
            if (ar_prev && !r_done) begin
                if (r_cnt >= r_d) begin
                    bus.axi_r_valid_i = 1'b1;
                    bus.axi_r_data_i  = rdat;
                    bus.axi_r_resp_i  = resp;
                    bus.axi_r_last_i  = 1'b1;
                    if (bus.axi_r_ready_o) r_done = 1;
                end else r_cnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        slave_idle();

        exp_addr = {a[31:2], 2'b00};
        check("r_valid_pulses", rv_cnt, 1);
        check("protocol_violations", viol, 0);
        if (chk_lat) check("latency", rv_cyc, 3);
        if (rd) begin
            check("ar_addr", ar_addr, exp_addr);
            check("ar_len_size_burst_id", {ar_len, ar_size, ar_burst, ar_id}, {8'd0, 3'd2, 2'b01, 8'd0});
            check("rd_data", rv_data, a[2] ? rdat[63:32] : rdat[31:0]);
        end else begin
            check("aw_addr", aw_addr, exp_addr);
            check("aw_len_size_burst_id", {aw_len, aw_size, aw_burst, aw_id}, {8'd0, 3'd2, 2'b01, 8'd0});
            check("w_data", w_data, {d, d});
            check("w_strb", w_strb, a[2] ? {be, 4'h0} : {4'h0, be});
            check("w_last", w_last, 1'b1);
            check("wr_rsp_data", rv_data, 32'h0);
        end
        if (resp != 2'b00) begin
            exp_err = 1;
            if (exp_err_cnt < 255) exp_err_cnt++;
        end
        check_err();
    endtask

    initial begin
        logic [31:0] ra, rd32;
        logic [63:0] rdat;
        rst = 1'b1;
        bus.tcdm_req_i = 1'b0; bus.tcdm_add_i = '0; bus.tcdm_wen_i = 1'b0;
        bus.tcdm_be_i = '0; bus.tcdm_data_i = '0;
        slave_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_w_ar_valid", {bus.axi_aw_valid_o, bus.axi_w_valid_o, bus.axi_ar_valid_o}, 3'b000);
        check("rst_b_r_ready", {bus.axi_b_ready_o, bus.axi_r_ready_o}, 2'b00);
        check("rst_tcdm_r_valid", bus.tcdm_r_valid_o, 1'b0);
        check("rst_tcdm_r_data", bus.tcdm_r_data_o, 32'h0);
        check("rst_busy", busy, 1'b0);
        check_err();
        rst = 1'b0;
        @(posedge clk); #1;
        bus.tcdm_req_i = 1'b1; #1;
        check("gnt_follows_req_hi", bus.tcdm_gnt_o, 1'b1);
        bus.tcdm_req_i = 1'b0; #1;
        check("gnt_follows_req_lo", bus.tcdm_gnt_o, 1'b0);
        @(posedge clk); #1;

        txn(32'h1004, 1'b0, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 64'h0, 2'b00, 1'b0, 1'b1);
        txn(32'h2000, 1'b1, 4'hF, 32'h0, 0, 0, 0, 0, 0, 64'h11223344_55667788, 2'b00, 1'b0, 1'b1);
        txn(32'h2004, 1'b1, 4'hF, 32'h0, 0, 0, 0, 0, 0, 64'h11223344_55667788, 2'b00, 1'b0, 1'b1);
        txn(32'h3000, 1'b0, 4'h0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 64'h0, 2'b00, 1'b0, 1'b1);
        txn(32'h4008, 1'b0, 4'h5, 32'h01234567, 3, 0, 0, 0, 0, 64'h0, 2'b00, 1'b0, 1'b0);
        txn(32'h400C, 1'b0, 4'hA, 32'h89ABCDEF, 0, 3, 2, 0, 0, 64'h0, 2'b00, 1'b0, 1'b0);

        txn(32'h5000, 1'b0, 4'h3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 64'h0, 2'b00, 1'b1, 1'b1);
        txn(32'h5004, 1'b1, 4'hF, 32'h0, 0, 0, 0, 1, 2, 64'hFEDCBA98_76543210, 2'b00, 1'b1, 1'b0);
        txn(32'h5008, 1'b0, 4'hC, 32'h5A5A5A5A, 1, 2, 0, 0, 0, 64'h0, 2'b00, 1'b1, 1'b0);
        txn(32'h500C, 1'b1, 4'hF, 32'h0, 0, 0, 0, 0, 0, 64'h0BADF00D_600DCAFE, 2'b00, 1'b0, 1'b1);

        txn(32'h6000, 1'b0, 4'hF, 32'h11111111, 0, 0, 0, 0, 0, 64'h0, 2'b10, 1'b0, 1'b1);
        txn(32'h6004, 1'b0, 4'hF, 32'h22222222, 0, 0, 0, 0, 0, 64'h0, 2'b10, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra   = $urandom & 32'hFFFF_FFFC;
            rd32 = $urandom;
            rdat = {$urandom, $urandom};
            txn(ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rd32,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), rdat,
                ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00,
                1'($urandom_range(0, 1)), 1'b0);
        end
        bus.tcdm_req_i = 1'b0;
        @(posedge clk); #1;

        // abandon a read while the bridge waits for R
        bus.tcdm_req_i = 1'b1; bus.tcdm_wen_i = 1'b1; bus.tcdm_add_i = 32'h7004;
        @(posedge clk); #1;
        bus.tcdm_req_i = 1'b0;
        bus.axi_ar_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.axi_ar_ready_i = 1'b0;
        @(posedge clk); #1;
        check("abort_in_rd_resp_r_ready", bus.axi_r_ready_o, 1'b1);
        check("abort_in_rd_resp_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valids", {bus.axi_aw_valid_o, bus.axi_w_valid_o, bus.axi_ar_valid_o}, 3'b000);
        check("abort_readys", {bus.axi_b_ready_o, bus.axi_r_ready_o}, 2'b00);
        check("abort_r_valid", bus.tcdm_r_valid_o, 1'b0);
        check("abort_r_data", bus.tcdm_r_data_o, 32'h0);
        check("abort_busy", busy, 1'b0);
        exp_err = 0;
        exp_err_cnt = 0;
        check_err();
        txn(32'h7008, 1'b1, 4'hF, 32'h0, 0, 0, 0, 0, 0, 64'h13579BDF_2468ACE0, 2'b00, 1'b0, 1'b1);
        txn(32'h700C, 1'b0, 4'h9, 32'h0F0F0F0F, 0, 0, 0, 0, 0, 64'h0, 2'b00, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
